// File: rtl/arith_engine.sv
// Single-channel ADD/SUB/MUL engine with valid/ready handshakes on both sides.
// MUL is an iterative shift-add, one partial product per cycle, LSB of B first.
module arith_engine #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [1:0]         out_op,
    output logic               out_err,
    output logic               busy
);
    // state | meaning
    // IDLE  | waiting for an operand/op; only state with in_ready high
    // CALC  | MUL in progress, one partial product per cycle for WIDTH cycles
    // DONE  | first cycle forms the result, then holds it until out_ready

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = 2 * WIDTH;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]    a_shift;
    logic [RW-1:0]    acc;
    logic [CW-1:0]    cnt;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            a_shift    <= '0;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        a_q     <= in_a;
                        b_q     <= in_b;
                        a_shift <= {{WIDTH{1'b0}}, in_a};
                        acc     <= '0;
                        cnt     <= CW'(WIDTH);
                        state   <= (in_op == OP_MUL) ? CALC : DONE;
                    end
                end
                CALC: begin
                    // b_q is consumed LSB first; cnt==1 marks the final iteration
                    if (b_q[0]) begin
                        acc <= acc + a_shift;
                    end
                    a_shift <= a_shift << 1;
                    b_q     <= b_q >> 1;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_op    <= op_q;
                        out_err   <= 1'b0;
                        case (op_q)
                            OP_ADD:  out_result <= RW'(a_q) + RW'(b_q);
                            OP_SUB:  out_result <= RW'(a_q) - RW'(b_q);
                            OP_MUL:  out_result <= acc;
                            default: begin
                                out_result <= '0;
                                out_err    <= 1'b1;
                            end
                        endcase
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_engine.sv
// Directed bench for arith_engine (WIDTH=4) with hand-computed expected results.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_arith_engine;
    localparam int WIDTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [3:0]   in_a = 4'h0;
    logic [3:0]   in_b = 4'h0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_result;
    logic [1:0]   out_op;
    logic         out_err;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    arith_engine #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] op,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp_res, input logic exp_err,
                       input int exp_lat);
        int lat;
        accept(tag, op, a, b);
        wait_valid(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, 32'(out_result), 32'(exp_res));
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        chk({tag, "_op"}, 32'(out_op), 32'(op));
        handshake(tag);
    endtask

    initial begin
        int lat;

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // add / sub, including 0 and all-ones operands
        run("add_ff", 2'b00, 4'hF, 4'hF, 8'h1E, 1'b0, 1);
        run("add_00", 2'b00, 4'h0, 4'h0, 8'h00, 1'b0, 1);
        run("sub_3_5", 2'b01, 4'h3, 4'h5, 8'hFE, 1'b0, 1);
        run("sub_5_3", 2'b01, 4'h5, 4'h3, 8'h02, 1'b0, 1);
        run("sub_0_f", 2'b01, 4'h0, 4'hF, 8'hF1, 1'b0, 1);

        // multiply: full WIDTH iterations even for b==0
        run("mul_ff", 2'b10, 4'hF, 4'hF, 8'hE1, 1'b0, 5);
        run("mul_7_0", 2'b10, 4'h7, 4'h0, 8'h00, 1'b0, 5);
        run("mul_f_1", 2'b10, 4'hF, 4'h1, 8'h0F, 1'b0, 5);
        run("mul_5_a", 2'b10, 4'h5, 4'hA, 8'h32, 1'b0, 5);

        // backpressure on a 6*9 multiply
        accept("bp", 2'b10, 4'h6, 4'h9);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_result_hold", 32'(out_result), 32'h36);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        handshake("bp");

        // reset during the second CALC cycle aborts the multiply
        accept("rst_mul", 2'b10, 4'hF, 4'hF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_result", 32'(out_result), 32'd0);
        chk("abort_out_op", 32'(out_op), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        run("add_1_2", 2'b00, 4'h1, 4'h2, 8'h03, 1'b0, 1);

        // reserved op, then a new op presented while the result is held
        accept("rsv", 2'b11, 4'hA, 4'hB);
        wait_valid(lat);
        chk("rsv_latency", 32'(lat), 32'd1);
        chk("rsv_result", 32'(out_result), 32'd0);
        chk("rsv_err", 32'(out_err), 32'd1);
        chk("rsv_op", 32'(out_op), 32'd3);
        in_op    = 2'b00;
        in_a     = 4'h1;
        in_b     = 4'h1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_ignore_result", 32'(out_result), 32'd0);
            chk("busy_ignore_err", 32'(out_err), 32'd1);
            chk("busy_ignore_op", 32'(out_op), 32'd3);
            chk("busy_ignore_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        handshake("rsv");

        run("add_f_1", 2'b00, 4'hF, 4'h1, 8'h10, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
